// File: rtl/com_send_arb_if.sv
// Bundle of the collect-side request/done lines and the console send channel.
// slave: the arbiter side; master: requesters plus the console channel model.
interface com_send_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   fs_req;
  logic [NREQ-1:0]   fd_req;
  logic [4*NREQ-1:0] req_btype;
  logic              fs_send;
  logic              fd_send;
  logic [3:0]        send_btype;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              timeout_err;

  modport slave (
    input  fs_req,
    input  req_btype,
    input  fd_send,
    output fd_req,
    output fs_send,
    output send_btype,
    output grant,
    output busy,
    output timeout_err
  );

  modport master (
    output fs_req,
    output req_btype,
    output fd_send,
    input  fd_req,
    input  fs_send,
    input  send_btype,
    input  grant,
    input  busy,
    input  timeout_err
  );
endinterface

// File: rtl/com_send_arb.sv
// Round-robin arbiter giving four collect-side requesters the single console send
// channel; latches the winner's btype, relays done to the owner, aborts stalled sends.
module com_send_arb #(
  parameter int         NREQ    = 4,
  parameter logic [7:0] TIMEOUT = 8'hC0
) (
  input logic           clk,
  input logic           rst,
  com_send_arb_if.slave bus
);

  // state | meaning
  // IDLE  | no owner; scan requests starting at last+1
  // SEND  | fs_send high; wait for fd_send or timeout
  // RLSE  | fs_send low; wait for fd_send to drop
  // ACK   | fd_req to owner until it drops its fs_req
  // DONE  | pointer moves to owner, grant cleared

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    SEND = 5'b00010,
    RLSE = 5'b00100,
    ACK  = 5'b01000,
    DONE = 5'b10000
  } state_e;

  state_e           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [3:0]       btype_q, btype_d;
  logic [7:0]       num_q, num_d;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic             expired;
  logic             abort;

  // first pending requester after the previous owner, wrapping modulo NREQ
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last_q + IDX_W'(k);
      if (!pick_vld && bus.fs_req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign expired = ({1'b0, num_q} + 9'd1) >= {1'b0, TIMEOUT};

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    btype_d = btype_q;
    num_d   = '0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d           = SEND;
          gidx_d            = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          btype_d           = bus.req_btype[{pick_idx, 2'b00} +: 4];
        end
      end
      SEND: begin
        num_d = num_q + 8'd1;
        if (bus.fd_send) begin
          state_d = RLSE;
        end else if (expired) begin
          state_d = RLSE;
          abort   = 1'b1;
        end
      end
      RLSE: begin
        if (!bus.fd_send) state_d = ACK;
      end
      // a requester that already dropped fs_req is released on the first ACK cycle
      ACK: begin
        if (!bus.fs_req[gidx_q]) state_d = DONE;
      end
      DONE: begin
        last_d  = gidx_q;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      btype_q <= 4'h0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      btype_q <= btype_d;
      num_q   <= num_d;
    end
  end

  assign bus.fs_send     = (state_q == SEND);
  assign bus.fd_req      = (state_q == ACK) ? grant_q : '0;
  assign bus.busy        = (state_q != IDLE);
  assign bus.grant       = grant_q;
  assign bus.send_btype  = btype_q;
  assign bus.timeout_err = abort;

  a_state_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(state_q));
  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_fd_req_owner: assert property (@(posedge clk) disable iff (rst) (bus.fd_req & ~grant_q) == '0);
  a_num_bound: assert property (@(posedge clk) disable iff (rst) num_q <= TIMEOUT);

endmodule
